// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST controller: FSM states, march phases
// and the expected-data function used by both the write path and the checker.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrA,
    StRdA,
    StWrB,
    StRdB,
    StFlush,
    StDone
  } state_e;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  localparam logic [31:0] DefPattern = 32'hA5A5_5A5A;

  // Address folded into the pattern so that aliased locations read back wrong data.
  function automatic logic [63:0] expected(input logic [63:0] pattern,
                                           input logic [31:0] addr,
                                           input phase_e      phase);
    logic [63:0] a;
    a = pattern ^ {32'h0, addr};
    return (phase == PH_B) ? ~a : a;
  endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-response checker: pending-tag register, comparator against the expected pattern,
// and first-failure capture.
module mem_bist_checker
  import mem_bist_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 4,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DefPattern)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              capture_en_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  phase_e            issue_phase_i,
  input  logic [DATA_W-1:0] mem_data_out_i,
  input  logic              mem_valid_out_i,
  output logic              mismatch_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output phase_e            fail_phase_o,
  output logic [DATA_W-1:0] fail_data_o
);

  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  phase_e            pend_phase_q;
  logic [DATA_W-1:0] exp_data;

  // Tag trails the presented read by one cycle, lining up with the memory's response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_phase_q <= PH_A;
    end else if (clear_i) begin
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_phase_q <= PH_A;
    end else begin
      pend_q       <= issue_i;
      pend_addr_q  <= issue_addr_i;
      pend_phase_q <= issue_phase_i;
    end
  end

  assign exp_data   = DATA_W'(expected(64'(PATTERN), 32'(pend_addr_q), pend_phase_q));
  assign mismatch_o = pend_q && (!mem_valid_out_i || (mem_data_out_i != exp_data));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_addr_o  <= '0;
      fail_phase_o <= PH_A;
      fail_data_o  <= '0;
    end else if (clear_i) begin
      fail_addr_o  <= '0;
      fail_phase_o <= PH_A;
      fail_data_o  <= '0;
    end else if (capture_en_i && mismatch_o) begin
      fail_addr_o  <= pend_addr_q;
      fail_phase_o <= pend_phase_q;
      fail_data_o  <= mem_data_out_i;
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-test initiator for the synchronous memory: write A, read A, write ~A, read ~A,
// reporting pass/fail and the first failing address, phase and data.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 4,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DefPattern)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              mem_enable_o,
  output logic              mem_read_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  input  logic [DATA_W-1:0] mem_data_out_i,
  input  logic              mem_valid_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic              fail_phase_o,
  output logic [DATA_W-1:0] fail_data_o
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              test_start;
  logic              mismatch;
  phase_e            fail_phase;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    test_start = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StWrA;
          addr_d     = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          test_start = 1'b1;
        end
      end
      StWrA, StRdA, StWrB, StRdB: begin
        if (mismatch) begin
          state_d = StDone;
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (addr_q == LastAddr) begin
          addr_d = '0;
          unique case (state_q)
            StWrA:   state_d = StRdA;
            StRdA:   state_d = StWrB;
            StWrB:   state_d = StRdB;
            default: state_d = StFlush;
          endcase
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      StFlush: begin
        // Last read-B response is checked here.
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = !mismatch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory command is registered from the next state so the op lands the cycle it is named for.
  always_comb begin
    en_d    = 1'b0;
    rw_d    = 1'b0;
    wdata_d = '0;
    unique case (state_d)
      StWrA: begin
        en_d    = 1'b1;
        rw_d    = 1'b1;
        wdata_d = DATA_W'(expected(64'(PATTERN), 32'(addr_d), PH_A));
      end
      StWrB: begin
        en_d    = 1'b1;
        rw_d    = 1'b1;
        wdata_d = DATA_W'(expected(64'(PATTERN), 32'(addr_d), PH_B));
      end
      StRdA, StRdB: en_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  mem_bist_checker #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .PATTERN (PATTERN)
  ) u_checker (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (test_start),
    .capture_en_i    (busy_q),
    .issue_i         (en_q && !rw_q),
    .issue_addr_i    (addr_q),
    .issue_phase_i   ((state_q == StRdB) ? PH_B : PH_A),
    .mem_data_out_i  (mem_data_out_i),
    .mem_valid_out_i (mem_valid_out_i),
    .mismatch_o      (mismatch),
    .fail_addr_o     (fail_addr_o),
    .fail_phase_o    (fail_phase),
    .fail_data_o     (fail_data_o)
  );

  assign fail_phase_o     = fail_phase;
  assign mem_enable_o     = en_q;
  assign mem_read_write_o = rw_q;
  assign mem_address_o    = addr_q;
  assign mem_data_in_o    = wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a 16x32 synchronous memory model that can inject
// a stuck bit, an address alias or a dropped read-valid.
module tb_mem_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_enable;
  logic        mem_read_write;
  logic [3:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic        mem_valid_out = 1'b0;
  logic        busy, done, pass, fail_phase;
  logic [3:0]  fail_addr;
  logic [31:0] fail_data;

  logic [31:0] mem [16];
  int          mode = 0;  // 0 clean, 1 addr7 bit0 stuck-1, 2 addr12 aliases 4, 3 drop valid on B(15)
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;
  int          busy_cnt = 0;

  mem_bist_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .mem_enable_o     (mem_enable),
    .mem_read_write_o (mem_read_write),
    .mem_address_o    (mem_address),
    .mem_data_in_o    (mem_data_in),
    .mem_data_out_i   (mem_data_out),
    .mem_valid_out_i  (mem_valid_out),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .fail_addr_o      (fail_addr),
    .fail_phase_o     (fail_phase),
    .fail_data_o      (fail_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : mem_model
    logic [3:0] ea;
    ea = (mode == 2 && mem_address == 4'd12) ? 4'd4 : mem_address;
    mem_valid_out <= 1'b0;
    if (mem_enable) begin
      if (mem_read_write) begin
        mem[ea] <= (mode == 1 && ea == 4'd7) ? (mem_data_in | 32'h1) : mem_data_in;
      end else begin
        mem_data_out  <= mem[ea];
        mem_valid_out <= !(mode == 3 && ea == 4'd15 && mem[ea] == 32'h5A5A_A5AA);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (busy) busy_cnt++;
  endtask

  // Pulses start so that it is sampled at E0; returns #1 after E0.
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    edge_n   = 0;
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic run_to_done(input int limit);
    while (!done && edge_n < limit) step();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_pass"}, 32'(pass), 0);
    check_val({tag, "_en"}, 32'(mem_enable), 0);
    check_val({tag, "_rw"}, 32'(mem_read_write), 0);
    check_val({tag, "_addr"}, 32'(mem_address), 0);
    check_val({tag, "_wdata"}, mem_data_in, 0);
    check_val({tag, "_faddr"}, 32'(fail_addr), 0);
    check_val({tag, "_fphase"}, 32'(fail_phase), 0);
    check_val({tag, "_fdata"}, fail_data, 0);
  endtask

  task automatic check_fail(input string tag, input int done_edge, input logic [3:0] faddr,
                            input logic fphase, input logic [31:0] fdata);
    check_val({tag, "_done_edge"}, 32'(edge_n), 32'(done_edge));
    check_val({tag, "_pass"}, 32'(pass), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_en"}, 32'(mem_enable), 0);
    check_val({tag, "_faddr"}, 32'(fail_addr), 32'(faddr));
    check_val({tag, "_fphase"}, 32'(fail_phase), 32'(fphase));
    check_val({tag, "_fdata"}, fail_data, fdata);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b1;

    // Clean run with timing landmarks
    mode = 0;
    launch();
    check_val("c0_busy", 32'(busy), 1);
    check_val("c0_en", 32'(mem_enable), 1);
    check_val("c0_rw", 32'(mem_read_write), 1);
    check_val("c0_addr", 32'(mem_address), 0);
    check_val("c0_wdata", mem_data_in, 32'hA5A5_5A5A);
    while (edge_n < 3) step();
    check_val("c3_addr", 32'(mem_address), 3);
    check_val("c3_wdata", mem_data_in, 32'hA5A5_5A59);
    while (edge_n < 16) step();
    check_val("c16_en", 32'(mem_enable), 1);
    check_val("c16_rw", 32'(mem_read_write), 0);
    check_val("c16_wdata", mem_data_in, 0);
    while (edge_n < 32) step();
    check_val("c32_rw", 32'(mem_read_write), 1);
    check_val("c32_addr", 32'(mem_address), 0);
    check_val("c32_wdata", mem_data_in, 32'h5A5A_A5A5);
    while (edge_n < 64) step();
    check_val("c64_en", 32'(mem_enable), 0);
    check_val("c64_busy", 32'(busy), 1);
    check_val("c64_done", 32'(done), 0);
    run_to_done(200);
    check_val("clean_done_edge", 32'(edge_n), 65);
    check_val("clean_pass", 32'(pass), 1);
    check_val("clean_busy", 32'(busy), 0);
    check_val("clean_busy_cycles", 32'(busy_cnt), 65);
    check_val("clean_faddr", 32'(fail_addr), 0);
    check_val("clean_fdata", fail_data, 0);

    // Bit 0 of addr 7 stuck at 1: A(7) already has bit 0 set, so the fault shows in phase B
    mode = 1;
    launch();
    run_to_done(200);
    check_fail("stuck", 57, 4'd7, 1'b1, 32'h5A5A_A5A3);
    step();
    check_val("stuck_en_held", 32'(mem_enable), 0);
    check_val("stuck_done_held", 32'(done), 1);

    // Address 12 aliased onto 4
    mode = 2;
    launch();
    run_to_done(200);
    check_fail("alias", 22, 4'd4, 1'b0, 32'hA5A5_5A56);

    // Dropped valid on the phase-B read of 15, caught in FLUSH
    mode = 3;
    launch();
    run_to_done(200);
    check_fail("noval", 65, 4'd15, 1'b1, 32'h5A5A_A5AA);

    // Reset mid-test, no resume, then a clean run
    mode = 0;
    launch();
    while (edge_n < 40) step();
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("midrst_hold");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check_val("noresume_busy", 32'(busy), 0);
    check_val("noresume_en", 32'(mem_enable), 0);
    launch();
    run_to_done(200);
    check_val("postrst_done_edge", 32'(edge_n), 65);
    check_val("postrst_pass", 32'(pass), 1);

    // Start pulses while busy are ignored; start held into DONE restarts
    launch();
    while (!done && edge_n < 200) begin
      step();
      case (edge_n)
        10, 50, 60: start = 1'b1;
        11, 51:     start = 1'b0;
        default: ;
      endcase
    end
    check_val("ign_done_edge", 32'(edge_n), 65);
    check_val("ign_pass", 32'(pass), 1);
    check_val("ign_busy_cycles", 32'(busy_cnt), 65);
    step();
    start = 1'b0;
    check_val("restart_busy", 32'(busy), 1);
    check_val("restart_done", 32'(done), 0);
    check_val("restart_pass", 32'(pass), 0);
    check_val("restart_en", 32'(mem_enable), 1);
    check_val("restart_addr", 32'(mem_address), 0);
    check_val("restart_wdata", mem_data_in, 32'hA5A5_5A5A);
    run_to_done(400);
    check_val("restart_done_edge", 32'(edge_n), 131);
    check_val("restart_pass2", 32'(pass), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
